buffer_write_ctrl: RTL
======================

BUFFER_WRITE_CTRL -- requirements
Module: buffer_write_ctrl

Interface
REQ-001 SHALL have parameter X_MAC, default 4, kernels per port (buffers per mesh port).
REQ-002 SHALL have parameter X_MESH, default 16, mesh ports.
REQ-003 SHALL have parameter ADDR_LEN, default 13, per-buffer address width.
REQ-004 SHALL have parameter DATA_LEN, default 32, per-buffer word width.
REQ-005 SHALL derive BUFFER_NUM=X_MAC*X_MESH, DATAWIDTH=BUFFER_NUM*DATA_LEN, ADDRWIDTH=BUFFER_NUM*ADDR_LEN.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port start, input, 1, one-cycle request to begin a transfer.
REQ-009 SHALL have port cfg_base, input, ADDR_LEN, starting buffer address, sampled on accepted start.
REQ-010 SHALL have port cfg_rows, input, ADDR_LEN+1, number of address rows to fill, sampled on accepted start.
REQ-011 SHALL have ports s_data (input, X_MAC*DATA_LEN), s_valid (input, 1), s_ready (output, 1): input stream, one beat = X_MAC words, word k in bits k*DATA_LEN +: DATA_LEN.
REQ-012 SHALL have outputs dina (DATAWIDTH), addra (ADDRWIDTH), wea (BUFFER_NUM): buffer-pool write port A, buffer b=kernel+port*X_MAC at slice b.
REQ-013 SHALL have outputs busy (1), done (1, one-cycle pulse), err (1).

Function
REQ-014 SHALL implement states IDLE, WRITE, DONE.
REQ-015 IDLE: start=1 with cfg_rows!=0 -> WRITE, load addr=cfg_base, port=0, rows_left=cfg_rows; start with cfg_rows=0 -> DONE.
REQ-016 start SHALL be ignored outside IDLE.
REQ-017 s_ready SHALL be 1 only in WRITE; a beat is accepted when s_valid&&s_ready.
REQ-018 On accepted beat, next cycle: wea bits port*X_MAC..port*X_MAC+X_MAC-1 =1, all others 0; every dina port slice = s_data; every addra slice = addr (write latency exactly one cycle, outputs registered).
REQ-019 wea SHALL be all-zero in any cycle following a non-accepted cycle; dina/addra hold last value.
REQ-020 After each beat port increments; at port=X_MESH-1 port wraps to 0, addr increments, rows_left decrements.
REQ-021 When rows_left reaches 0 after the final beat -> DONE; s_ready drops in the same edge (no extra beat accepted).
REQ-022 DONE SHALL assert done for exactly one cycle, then -> IDLE; done coincides with or follows the final wea pulse.
REQ-023 busy SHALL be 1 in WRITE and DONE, 0 in IDLE.
REQ-024 addr SHALL be ADDR_LEN bits; increment past 2**ADDR_LEN-1 wraps to 0.
REQ-025 s_valid gaps SHALL stall counters without loss or duplication.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, wea=0, dina=0, addra=0, s_ready=0, busy=0, done=0, err=0, counters 0.
REQ-027 Reset mid-WRITE SHALL abort the transfer; no done pulse; wea=0 immediately.

Configuration
REQ-028 Macro BUF_WR_WRAP_CHECK_EN defined: err SHALL set (sticky until reset or next accepted start) in the cycle addr wraps from 2**ADDR_LEN-1 to 0 while rows_left!=0; transfer continues.
REQ-029 Macro not defined: no wrap detection logic; err tied to 0.

Verification
REQ-030 Defaults, start cfg_base=0x010 cfg_rows=1, 16 back-to-back beats -> wea=0x000F,0x00F0,... one per cycle, addra slices 0x010, done one cycle after last wea, busy low after.
REQ-031 cfg_rows=2, s_valid toggling 1/0 -> 32 write pulses total, second row addra=0x011, no duplicated port.
REQ-032 start with cfg_rows=0 -> done pulse 1 cycle later, wea never nonzero.
REQ-033 rst_n low after 5 beats -> wea=0 same cycle, IDLE, no done; new start works from cfg_base.
REQ-034 With BUF_WR_WRAP_CHECK_EN, cfg_base=0x1FFF cfg_rows=2 -> second row addra=0x0000, err=1; without macro err stays 0.
REQ-035 start pulsed during WRITE -> ignored, counters and cfg unchanged.

Source files
------------

// File: rtl/buffer_write_ctrl.sv
//------------------------------------------------------------------------------
// Module      : buffer_write_ctrl
// Description : Streams X_MAC-word beats into a pool of X_MAC*X_MESH buffers.
//               Each beat is broadcast on every data slice; wea selects the
//               X_MAC buffers of the current mesh port. Ports advance per
//               beat, the row address advances after the last port.
//               Optional feature macro: BUF_WR_WRAP_CHECK_EN (sticky err when
//               the row address wraps while rows remain).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module buffer_write_ctrl #(
  parameter  int X_MAC      = 4,
  parameter  int X_MESH     = 16,
  parameter  int ADDR_LEN   = 13,
  parameter  int DATA_LEN   = 32,
  localparam int BUFFER_NUM = X_MAC * X_MESH,
  localparam int DATAWIDTH  = BUFFER_NUM * DATA_LEN,
  localparam int ADDRWIDTH  = BUFFER_NUM * ADDR_LEN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_LEN-1:0]       cfg_base,
  input  logic [ADDR_LEN:0]         cfg_rows,
  input  logic [X_MAC*DATA_LEN-1:0] s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [DATAWIDTH-1:0]      dina,
  output logic [ADDRWIDTH-1:0]      addra,
  output logic [BUFFER_NUM-1:0]     wea,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int PORT_W = (X_MESH > 1) ? $clog2(X_MESH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_LEN-1:0]     r_addr;
  logic [PORT_W-1:0]       r_port;
  logic [ADDR_LEN:0]       r_rows_left;
  logic [DATAWIDTH-1:0]    r_dina;
  logic [ADDRWIDTH-1:0]    r_addra;
  logic [BUFFER_NUM-1:0]   r_wea;
  logic                    r_done;
  logic                    w_accept;
  logic                    w_last_port;
  logic                    w_final;
  logic                    w_start_ok;
  logic [BUFFER_NUM-1:0]   w_wea_pat;

  assign w_accept    = s_valid && (r_state == S_WRITE);
  assign w_last_port = (r_port == PORT_W'(X_MESH - 1));
  assign w_final     = w_accept && w_last_port && (r_rows_left == (ADDR_LEN+1)'(1));
  assign w_start_ok  = start && (r_state == S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; start only honoured in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (cfg_rows != '0) ? S_WRITE : S_DONE;
      S_WRITE: if (w_final) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Write-enable pattern: the X_MAC lanes of the current port
  always_comb begin
    w_wea_pat = '0;
    for (int p = 0; p < X_MESH; p++) begin
      if (r_port == PORT_W'(p)) w_wea_pat[p*X_MAC +: X_MAC] = '1;
    end
  end

  // Address / port / row counters; they only move on an accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_port      <= '0;
      r_rows_left <= '0;
    end else if (w_start_ok) begin
      r_addr      <= cfg_base;
      r_port      <= '0;
      r_rows_left <= cfg_rows;
    end else if (w_accept) begin
      if (w_last_port) begin
        r_port      <= '0;
        r_addr      <= r_addr + ADDR_LEN'(1);
        r_rows_left <= r_rows_left - (ADDR_LEN+1)'(1);
      end else begin
        r_port      <= r_port + PORT_W'(1);
      end
    end
  end

  // Registered write port: one-cycle latency, data/address hold between beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wea   <= '0;
      r_dina  <= '0;
      r_addra <= '0;
    end else begin
      r_wea <= '0;
      if (w_accept) begin
        r_wea   <= w_wea_pat;
        r_dina  <= {X_MESH{s_data}};
        r_addra <= {BUFFER_NUM{r_addr}};
      end
    end
  end

  // done follows the DONE state so it lands one cycle after the last write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= (r_state == S_DONE);
  end

`ifdef BUF_WR_WRAP_CHECK_EN
  logic r_err;
  logic w_wrap;

  assign w_wrap = w_accept && w_last_port && (r_addr == '1) &&
                  (r_rows_left != (ADDR_LEN+1)'(1));

  // Sticky wrap flag, cleared by the next accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_err <= 1'b0;
    else if (w_start_ok) r_err <= 1'b0;
    else if (w_wrap)     r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign s_ready = (r_state == S_WRITE);
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign wea     = r_wea;
  assign dina    = r_dina;
  assign addra   = r_addra;

endmodule

`default_nettype wire
